// File: rtl/class_ctrl_if.sv
// Classifier-controller signal bundle: key input, classifier handshake and display outputs.
// slave = controller side, master = environment (key/classifier) side.
interface class_ctrl_if;
    logic       key_state;
    logic       cls_done;
    logic [3:0] cls_result;
    logic       cls_start;
    logic [3:0] img_idx;
    logic [3:0] result;
    logic       result_valid;
    logic [3:0] led;
    logic       busy;

    modport master (
        output key_state, cls_done, cls_result,
        input  cls_start, img_idx, result, result_valid, led, busy
    );

    modport slave (
        input  key_state, cls_done, cls_result,
        output cls_start, img_idx, result, result_valid, led, busy
    );
endinterface

// File: rtl/class_ctrl.sv
// Key-driven inference sequencer: starts the classifier per key press, waits with timeout,
// shows the label on the leds or blinks an error pattern.
module class_ctrl #(
    parameter int NUM_IMG     = 10,
    parameter int TIMEOUT_CYC = 50_000_000,
    parameter int BLINK_HALF  = 12_500_000
) (
    input  logic         clk,
    input  logic         rst_n,
    class_ctrl_if.slave  bus
);
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int BW = (BLINK_HALF  > 1) ? $clog2(BLINK_HALF)  : 1;
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYC - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);
    localparam logic [3:0]    IMG_LAST   = 4'(NUM_IMG - 1);

    typedef enum logic [2:0] {IDLE, START, WAIT, SHOW, ERR} state_t;

    state_t        state_q;
    logic          key_q;
    logic [TW-1:0] tmo_q;
    logic [BW-1:0] blink_q;
    logic [3:0]    img_q, img_d;
    logic [3:0]    res_q;
    logic          rv_q;
    logic [3:0]    led_q;
    logic          start_q;
    logic          busy_q;
    logic          press_evt;

    assign press_evt = bus.key_state ^ key_q;
    assign img_d     = (img_q == IMG_LAST) ? 4'd0 : img_q + 4'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            key_q   <= 1'b0;
            tmo_q   <= '0;
            blink_q <= '0;
            img_q   <= 4'd0;
            res_q   <= 4'd0;
            rv_q    <= 1'b0;
            led_q   <= 4'd0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            key_q <= bus.key_state;
            case (state_q)
                IDLE: begin
                    if (press_evt) begin
                        state_q <= START;
                        start_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                START: begin
                    state_q <= WAIT;
                    start_q <= 1'b0;
                    tmo_q   <= '0;
                end
                WAIT: begin
                    // done is checked first so it wins a tie with the timeout
                    if (bus.cls_done) begin
                        state_q <= SHOW;
                        res_q   <= bus.cls_result;
                        rv_q    <= 1'b1;
                        led_q   <= bus.cls_result;
                        busy_q  <= 1'b0;
                    end else if (tmo_q == TMO_LAST) begin
                        state_q <= ERR;
                        rv_q    <= 1'b0;
                        led_q   <= 4'hF;
                        blink_q <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                SHOW: begin
                    if (press_evt) begin
                        state_q <= START;
                        img_q   <= img_d;
                        rv_q    <= 1'b0;
                        led_q   <= 4'd0;
                        start_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                ERR: begin
                    // img_q is left alone so the failed image is retried
                    if (press_evt) begin
                        state_q <= IDLE;
                        led_q   <= 4'd0;
                        blink_q <= '0;
                    end else if (blink_q == BLINK_LAST) begin
                        blink_q <= '0;
                        led_q   <= ~led_q;
                    end else begin
                        blink_q <= blink_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    rv_q    <= 1'b0;
                    led_q   <= 4'd0;
                    start_q <= 1'b0;
                    busy_q  <= 1'b0;
                    tmo_q   <= '0;
                    blink_q <= '0;
                end
            endcase
        end
    end

    assign bus.cls_start    = start_q;
    assign bus.img_idx      = img_q;
    assign bus.result       = res_q;
    assign bus.result_valid = rv_q;
    assign bus.led          = led_q;
    assign bus.busy         = busy_q;
endmodule

// File: tb/tb_class_ctrl.sv
// Scoreboard bench for class_ctrl: directed runs push expected img_idx/labels,
// a negedge monitor pops and compares on each cls_start and result_valid rise.
module tb_class_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    class_ctrl_if bus();

    class_ctrl #(.NUM_IMG(3), .TIMEOUT_CYC(16), .BLINK_HALF(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;
    logic [3:0] exp_idx[$];
    logic [3:0] exp_res[$];
    logic cs_prev = 1'b0;
    logic rv_prev = 1'b0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press();
        bus.key_state = ~bus.key_state;
    endtask

    task automatic wait_start();
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            seen = bus.cls_start;
        end
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL wait_start: no cls_start within 20 cycles");
        end
    endtask

    task automatic done(input logic [3:0] r);
        bus.cls_done   = 1'b1;
        bus.cls_result = r;
        step();
        bus.cls_done   = 1'b0;
        bus.cls_result = 4'd0;
    endtask

    task automatic run(input logic [3:0] idx, input logic [3:0] res);
        exp_idx.push_back(idx);
        exp_res.push_back(res);
        press();
        wait_start();
        repeat (5) step();
        done(res);
        chk("show_led", bus.led, res);
        chk("show_rv", bus.result_valid, 1);
        chk("show_busy", bus.busy, 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_start"}, bus.cls_start, 0);
        chk({tag, "_busy"},  bus.busy, 0);
        chk({tag, "_idx"},   bus.img_idx, 0);
        chk({tag, "_res"},   bus.result, 0);
        chk({tag, "_rv"},    bus.result_valid, 0);
        chk({tag, "_led"},   bus.led, 0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.cls_start) begin
                chk("start_width", cs_prev, 0);
                if (exp_idx.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL extra_start: img_idx %0d with none expected", bus.img_idx);
                end else begin
                    chk("start_idx", bus.img_idx, exp_idx.pop_front());
                end
            end
            if (bus.result_valid && !rv_prev) begin
                if (exp_res.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL extra_result: result %0h with none expected", bus.result);
                end else begin
                    chk("result", bus.result, exp_res.pop_front());
                end
            end
        end
        cs_prev = bus.cls_start;
        rv_prev = bus.result_valid;
    end

    initial begin
        bus.key_state  = 1'b0;
        bus.cls_done   = 1'b0;
        bus.cls_result = 4'd0;
        rst_n = 1'b0;
        repeat (2) step();
        chk_reset_outputs("rst");
        rst_n = 1'b1;
        step();

        // normal run then wrap over 3 images: 0,1,2,0
        run(4'd0, 4'd7);
        run(4'd1, 4'd3);
        run(4'd2, 4'd9);
        run(4'd0, 4'd5);

        // key toggles in START and WAIT must not queue a second start
        exp_idx.push_back(4'd1);
        exp_res.push_back(4'd2);
        press();
        wait_start();
        press();
        repeat (2) step();
        press();
        repeat (2) step();
        done(4'd2);
        chk("ign_led", bus.led, 4'd2);

        // timeout: ERR 16 cycles after WAIT entry, then blink
        exp_idx.push_back(4'd2);
        press();
        wait_start();
        repeat (16) step();
        chk("wait_busy", bus.busy, 1);
        chk("wait_led", bus.led, 0);
        step();
        chk("err_led", bus.led, 4'hF);
        chk("err_busy", bus.busy, 0);
        chk("err_rv", bus.result_valid, 0);
        repeat (3) step();
        chk("blink_hi", bus.led, 4'hF);
        step();
        chk("blink_lo", bus.led, 4'h0);
        repeat (4) step();
        chk("blink_hi2", bus.led, 4'hF);
        press();
        step();
        chk("idle_led", bus.led, 0);
        chk("idle_idx", bus.img_idx, 4'd2);

        // stray done in IDLE leaves result alone
        done(4'hA);
        step();
        chk("idle_result", bus.result, 4'd2);
        chk("idle_rv", bus.result_valid, 0);

        // retry same image; done coincides with last timeout count
        exp_idx.push_back(4'd2);
        exp_res.push_back(4'hE);
        press();
        wait_start();
        repeat (16) step();
        done(4'hE);
        chk("tie_led", bus.led, 4'hE);
        chk("tie_rv", bus.result_valid, 1);

        // reset in the middle of WAIT
        exp_idx.push_back(4'd0);
        press();
        wait_start();
        repeat (3) step();
        rst_n = 1'b0;
        bus.key_state = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        step();
        rst_n = 1'b1;
        step();
        done(4'd5);
        step();
        chk("post_rst_rv", bus.result_valid, 0);
        chk("post_rst_res", bus.result, 0);
        chk("post_rst_busy", bus.busy, 0);

        // key already high at reset release counts as one press
        rst_n = 1'b0;
        bus.key_state = 1'b1;
        step();
        exp_idx.push_back(4'd0);
        exp_res.push_back(4'd6);
        rst_n = 1'b1;
        wait_start();
        repeat (5) step();
        done(4'd6);
        chk("keyhi_rv", bus.result_valid, 1);
        step();

        chk("exp_idx_left", exp_idx.size(), 0);
        chk("exp_res_left", exp_res.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
